// File: rtl/amber48_uart_tx.sv
// 8N1 UART transmitter with a byte FIFO in front of it. Accepts the one-cycle
// store strobe from the data memory and serialises bytes LSB first onto txd_o.
module amber48_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tx_valid_i,
    input  logic [7:0]    tx_data_i,
    output logic          tx_ready_o,
    output logic          txd_o,
    output logic          busy_o,
    output logic [CW-1:0] fifo_count_o,
    output logic          drop_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          drop_q;

    logic [7:0]    mem [FIFO_DEPTH];

    logic push;
    logic pop;
    logic fifo_empty;
    logic bit_done;

    // Ready comes only from the registered count, so a pop in the same cycle
    // never opens the door for a push while full.
    assign tx_ready_o   = (count_q != CW'(FIFO_DEPTH));
    assign fifo_empty   = (count_q == '0);
    assign push         = tx_valid_i && tx_ready_o;
    assign bit_done     = (bit_cnt_q == BW'(CLKS_PER_BIT - 1));

    assign txd_o        = txd_q;
    assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;
    assign fifo_count_o = count_q;
    assign drop_o       = drop_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data_i;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            drop_q  <= tx_valid_i && !tx_ready_o;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                    txd_d     = 1'b0;
                end
            end

            ST_START: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                    txd_d     = shift_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end

            ST_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        // Shift right so the next data bit is always at [1].
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end

            ST_STOP: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = ST_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: tb/tb_amber48_uart_tx.sv
// Directed bench for amber48_uart_tx with 4 clocks per bit and a 4-deep FIFO;
// every txd_o sample of every frame is compared against the expected 8N1 waveform.
module tb_amber48_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_valid = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_ready;
    logic          txd;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          drop;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];

    amber48_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tx_valid_i  (tx_valid),
        .tx_data_i   (tx_data),
        .tx_ready_o  (tx_ready),
        .txd_o       (txd),
        .busy_o      (busy),
        .fifo_count_o(fifo_count),
        .drop_o      (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_txd"},   32'(txd), 32'd1);
        check({tag, "_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_drop"},  32'(drop), 32'd0);
    endtask

    task automatic push(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        exp_q.push_back(b);
        tick();
        tx_valid = 1'b0;
    endtask

    // Sample index i is the i-th cycle after the edge that dropped txd for the
    // start bit. Optionally injects a push so it lands on the stop-bit end edge.
    task automatic rx_frame(input int first, input bit inj, input logic [7:0] inj_data);
        logic [7:0] exp_b;
        logic [9:0] frame;
        logic [7:0] got;
        exp_b = exp_q.pop_front();
        frame = {1'b1, exp_b, 1'b0};
        got   = 8'h00;
        check($sformatf("busy_%02h", exp_b), 32'(busy), 32'd1);
        for (int i = first; i < 10 * CPB; i++) begin
            check($sformatf("txd_%02h_s%0d", exp_b, i), 32'(txd), 32'(frame[i / CPB]));
            if ((i % CPB == 2) && (i >= CPB) && (i < 9 * CPB)) begin
                got[i / CPB - 1] = txd;
            end
            if ((i == 10 * CPB - 1) && inj) begin
                tx_valid = 1'b1;
                tx_data  = inj_data;
                exp_q.push_back(inj_data);
            end
            tick();
        end
        if (inj) begin
            tx_valid = 1'b0;
        end
        check($sformatf("rx_byte_%02h", exp_b), 32'(got), 32'(exp_b));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Quiet line after reset
        for (int i = 0; i < 100; i++) begin
            check_idle("t1");
            tick();
        end

        // Single byte 0xA5
        push(8'hA5);
        check("t2_count", 32'(fifo_count), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);
        tick();
        rx_frame(0, 1'b0, 8'h00);
        check_idle("t2_end");

        // Three bytes back to back
        push(8'h01);
        check("t3_count1", 32'(fifo_count), 32'd1);
        push(8'h02);
        check("t3_count2", 32'(fifo_count), 32'd1);
        push(8'h03);
        check("t3_count3", 32'(fifo_count), 32'd2);
        rx_frame(1, 1'b0, 8'h00);
        rx_frame(0, 1'b0, 8'h00);
        rx_frame(0, 1'b0, 8'h00);
        check_idle("t3_end");

        // Fill to full, then a dropped push
        push(8'h10);
        push(8'h20);
        push(8'h30);
        push(8'h40);
        push(8'h50);
        check("t4_count_full", 32'(fifo_count), 32'd4);
        check("t4_ready_full", 32'(tx_ready), 32'd0);
        tx_valid = 1'b1;
        tx_data  = 8'hEE;
        tick();
        tx_valid = 1'b0;
        check("t4_drop_pulse", 32'(drop), 32'd1);
        check("t4_count_drop", 32'(fifo_count), 32'd4);
        tick();
        check("t4_drop_clear", 32'(drop), 32'd0);
        check("t4_count_hold", 32'(fifo_count), 32'd4);
        rx_frame(5, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            rx_frame(0, 1'b0, 8'h00);
        end
        check_idle("t4_end");

        // Simultaneous push and pop at count 2
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("t5_count_pre", 32'(fifo_count), 32'd2);
        rx_frame(1, 1'b1, 8'h44);
        check("t5_count_pushpop", 32'(fifo_count), 32'd2);
        for (int i = 0; i < 3; i++) begin
            rx_frame(0, 1'b0, 8'h00);
        end
        check_idle("t5_end");

        // Reset in the middle of a data bit with two bytes queued
        push(8'h3C);
        push(8'hA1);
        push(8'hB2);
        repeat (9) tick();
        check("t6_txd_mid", 32'(txd), 32'd0);
        check("t6_count_mid", 32'(fifo_count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_idle("t6_rst");
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("t6_release");
        push(8'h55);
        tick();
        rx_frame(0, 1'b0, 8'h00);
        check_idle("t6_end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
